data_memory_banked: RTL and testbench
=====================================

# data_memory_banked

Parametrised byte-addressable data memory for the RV32 core's load/store path, the successor to the current file-backed data RAM. It adds a valid/ready request port, byte/half/word access sizes with sign/zero extension, range checking, a hardware zero-fill after reset and, optionally, misaligned accesses split over two word cycles. Multi-byte values are big-endian: the byte at address A is the most significant byte, and a word at A occupies bits 31:24.

## Interface
- ADDR_WIDTH, 32, width of `req_addr`.
- DEPTH_WORDS, 1024, number of 32-bit words (default 4 KiB); power of two, ≥2.
- BASE_ADDR, 0, byte address of word 0; word-aligned.
---
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  32  load result (0 for stores and errors)
- rsp_error  out  1  access rejected, no memory effect

## Operation
- States: INIT, IDLE, SPLIT.
- INIT: a clear counter zeroes one word per cycle, words 0..DEPTH_WORDS-1; `req_ready`=0. After the last word, go to IDLE.
- IDLE: `req_ready`=1. A handshake (`req_valid & req_ready`) accepts the request.
- Error is flagged when any of these holds:
  - `req_size`=11.
  - Any byte of the access lies outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1]. Addresses never wrap.
  - The access is misaligned and the macro is undefined.
- On error: no write, `rsp_error`=1, `rsp_rdata`=0.
- Aligned access (within one word): a single cycle to the array, with byte write enables derived from size and offset.
- Store of a half at A: `req_wdata[15:8]` is written to A and `[7:0]` to A+1.
- Load of a half at A: the result is {mem[A],mem[A+1]}, then extended.
- Misaligned access crossing a word boundary (macro defined): first-word part in the accept cycle, then SPLIT for the second word at the next word address. First-word read bytes are latched and merged. Both partial writes are committed only if the whole access is in range.
- Store response: `rsp_valid`=1, `rsp_rdata`=0, `rsp_error`=0.
- Reset asserted in any state: outputs go to reset values and the state becomes INIT. A SPLIT in progress is abandoned, and the memory is re-zeroed.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, state INIT, clear counter 0.
- `req_ready` rises exactly DEPTH_WORDS cycles after the first cycle with `reset`=0.
- Aligned and error requests accepted at edge N: the response is at N+1, and `req_ready`=1 at N+1 so back-to-back requests are possible.
- Split request accepted at N: `req_ready`=0 during N+1 (SPLIT), the response is at N+2, and `req_ready` returns at N+2.
- The array read is synchronous (registered). `rsp_rdata` is held at 0 when `rsp_valid`=0.

## Configuration
- `DATA_MEMORY_MISALIGNED_EN` defined: misaligned accesses are split as above. Half accesses at offset 3 and word accesses at offsets 1–3 take 2 cycles.
- `DATA_MEMORY_MISALIGNED_EN` undefined:
  - Every access with `req_addr` not a multiple of its size is rejected with `rsp_error`=1 one cycle after accept.
  - This includes half accesses at offset 1, even though they do not cross a word.
  - The SPLIT state and the merge logic are not present.

## Structure
- Package `data_memory_pkg`: `mem_size_e` (BYTE/HALF/WORD/RSVD), `mem_state_e` (INIT/IDLE/SPLIT), and a function returning the 4-bit byte-enable mask for a given size and offset (lane 3 = bits 31:24 = offset 0).
- Sub-module `data_memory_array`: single-port DEPTH_WORDS×32 RAM with a 4-bit byte write enable and registered read. It has no reset; it is cleared by the INIT walk.

## Test plan
- Reset, release → `req_ready`=0 for 1024 cycles, then 1; a word load at 0x3FC returns 0x00000000.
- Word store 0x11223344 @0x10, then byte load @0x11 unsigned → 0x00000022; half load @0x12 → 0x00003344.
- Byte store 0x80 @0x20, signed byte load @0x20 → 0xFFFFFF80; unsigned → 0x00000080.
- Word store 0xAABBCCDD @0x102 (macro on) → response at N+2. Word loads then return 0x????AABB @0x100 (upper bytes unchanged) and 0xCCDD???? @0x104. With the macro off, the store yields `rsp_error`=1 at N+1 and memory is unchanged.
- Word load @0xFFE (macro on) and @0x1000 → `rsp_error`=1, `rsp_rdata`=0, no write; `req_size`=11 → error.
- Reset asserted during SPLIT → `rsp_valid` stays 0, INIT restarts, and all words read 0 afterwards.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types and byte-lane helper for the banked data memory.
// Lane 3 (bits 31:24) holds the byte at word offset 0 (big-endian).
package data_memory_pkg;

    localparam int unsigned WordBytes = 4;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeRsvd = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StSplit
    } mem_state_e;

    // Lanes touched in the first word; bits shifted past lane 0 spill into the next word.
    function automatic logic [3:0] be_mask(mem_size_e size, logic [1:0] offset);
        logic [3:0] base;
        unique case (size)
            SizeByte: base = 4'b1000;
            SizeHalf: base = 4'b1100;
            default:  base = 4'b1111;
        endcase
        return base >> offset;
    endfunction

endpackage

// File: rtl/data_memory_banked_if.sv
// Request/response bus between the load/store unit and data_memory_banked.
interface data_memory_banked_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_memory_array.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and registered read.
// No reset: contents are cleared by the owner's INIT walk.
module data_memory_array #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clock,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [3:0]                     we,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/data_memory_banked.sv
// Byte-addressable big-endian data memory with range checks and zero-fill after reset.
// Define DATA_MEMORY_MISALIGNED_EN to split word-crossing accesses over two cycles.
module data_memory_banked
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned BASE_ADDR   = 0
) (
    input logic                 clock,
    input logic                 reset,
    data_memory_banked_if.slave bus
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam int unsigned ExtW = ADDR_WIDTH + 2;
    localparam logic [ExtW-1:0] BaseExt  = ExtW'(BASE_ADDR);
    localparam logic [ExtW-1:0] SpanLast = ExtW'(WordBytes * DEPTH_WORDS - 1);

    mem_state_e state_q, state_d;
    logic [IdxW-1:0] clr_q, clr_d;

    // Request decode
    mem_size_e       size;
    logic [1:0]      off;
    logic [2:0]      nbytes;
    logic [ExtW:0]   rel_full;
    logic [ExtW-1:0] rel, end_rel;
    logic            in_range, req_err, accept, ready;
    logic [IdxW-1:0] word_idx;
    logic [31:0]     left_data, data_first;
    logic [3:0]      mask_first;

    // Array port
    logic [IdxW-1:0] arr_idx;
    logic [3:0]      arr_we;
    logic [31:0]     arr_wdata, arr_rdata;

    // Response context
    logic      rsp_valid_q, rsp_error_q, rsp_load_q, rsp_unsigned_q;
    mem_size_e rsp_size_q;
    logic [1:0] rsp_off_q;
    logic [31:0] shifted, extended;

`ifdef DATA_MEMORY_MISALIGNED_EN
    logic            crossing;
    logic [3:0]      mask_second;
    logic [31:0]     data_second;
    logic [7:0]      mask_pair;
    logic            rsp_split_q;
    logic [IdxW-1:0] split_idx_q;
    logic [3:0]      split_mask_q;
    logic [31:0]     split_data_q, first_rdata_q;
    logic [31:0]     merge_hi, merge_lo;
    logic [5:0]      merge_sh;
`else
    logic            misaligned;
`endif

    always_comb begin
        size = mem_size_e'(bus.req_size);
        off  = bus.req_addr[1:0];
        unique case (size)
            SizeByte: begin nbytes = 3'd1; left_data = {bus.req_wdata[7:0], 24'b0};  end
            SizeHalf: begin nbytes = 3'd2; left_data = {bus.req_wdata[15:0], 16'b0}; end
            default:  begin nbytes = 3'd4; left_data = bus.req_wdata;                end
        endcase
        // Extra top bit of rel_full is the borrow: set when the address is below BASE_ADDR.
        rel_full = {1'b0, ExtW'(bus.req_addr)} - {1'b0, BaseExt};
        rel      = rel_full[ExtW-1:0];
        end_rel  = rel + ExtW'(nbytes) - ExtW'(1);
        in_range = !rel_full[ExtW] && (end_rel <= SpanLast);
        word_idx = IdxW'(rel >> 2);
`ifdef DATA_MEMORY_MISALIGNED_EN
        crossing  = ({1'b0, off} + nbytes) > 3'd4;
        mask_pair = {be_mask(size, 2'b00), 4'b0} >> off;
        mask_first  = mask_pair[7:4];
        mask_second = mask_pair[3:0];
        {data_first, data_second} = {left_data, 32'b0} >> {off, 3'b000};
        req_err = (size == SizeRsvd) || !in_range;
`else
        misaligned = ((size == SizeHalf) && off[0]) || ((size == SizeWord) && (off != 2'b00));
        mask_first = be_mask(size, off);
        data_first = left_data >> {off, 3'b000};
        req_err    = (size == SizeRsvd) || !in_range || misaligned;
`endif
    end

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        ready     = 1'b0;
        accept    = 1'b0;
        arr_idx   = word_idx;
        arr_we    = 4'b0000;
        arr_wdata = data_first;
        case (state_q)
            StInit: begin
                arr_idx   = clr_q;
                arr_we    = 4'b1111;
                arr_wdata = 32'b0;
                clr_d     = clr_q + IdxW'(1);
                if (clr_q == IdxW'(DEPTH_WORDS - 1)) state_d = StIdle;
            end
            StIdle: begin
                ready  = 1'b1;
                accept = bus.req_valid;
                if (accept && !req_err) begin
                    arr_we = bus.req_write ? mask_first : 4'b0000;
`ifdef DATA_MEMORY_MISALIGNED_EN
                    if (crossing) state_d = StSplit;
`endif
                end
            end
`ifdef DATA_MEMORY_MISALIGNED_EN
            StSplit: begin
                arr_idx   = split_idx_q;
                arr_we    = split_mask_q;
                arr_wdata = split_data_q;
                state_d   = StIdle;
            end
`endif
            default: state_d = StInit;
        endcase
        // Reset abandons any pending write, including the second half of a split.
        if (reset) arr_we = 4'b0000;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StInit;
            clr_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_load_q     <= 1'b0;
            rsp_unsigned_q <= 1'b0;
            rsp_size_q     <= SizeByte;
            rsp_off_q      <= 2'b00;
`ifdef DATA_MEMORY_MISALIGNED_EN
            rsp_split_q    <= 1'b0;
            split_idx_q    <= '0;
            split_mask_q   <= 4'b0000;
            split_data_q   <= 32'b0;
            first_rdata_q  <= 32'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            rsp_valid_q <= 1'b0;
            if (accept) begin
                rsp_error_q    <= req_err;
                rsp_load_q     <= !bus.req_write && !req_err;
                rsp_unsigned_q <= bus.req_unsigned;
                rsp_size_q     <= size;
                rsp_off_q      <= off;
`ifdef DATA_MEMORY_MISALIGNED_EN
                if (!req_err && crossing) begin
                    rsp_split_q  <= 1'b1;
                    split_idx_q  <= word_idx + IdxW'(1);
                    split_mask_q <= bus.req_write ? mask_second : 4'b0000;
                    split_data_q <= data_second;
                end else begin
                    rsp_split_q <= 1'b0;
                    rsp_valid_q <= 1'b1;
                end
`else
                rsp_valid_q <= 1'b1;
`endif
            end
`ifdef DATA_MEMORY_MISALIGNED_EN
            if (state_q == StSplit) begin
                rsp_valid_q   <= 1'b1;
                first_rdata_q <= arr_rdata;
            end
`endif
        end
    end

    data_memory_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clock(clock),
        .addr (arr_idx),
        .we   (arr_we),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    always_comb begin
`ifdef DATA_MEMORY_MISALIGNED_EN
        // Left-justify the addressed bytes across the latched first word and the current one.
        merge_hi = rsp_split_q ? first_rdata_q : arr_rdata;
        merge_lo = rsp_split_q ? arr_rdata : 32'b0;
        merge_sh = {1'b0, rsp_off_q, 3'b000};
        shifted  = (merge_hi << merge_sh) | (merge_lo >> (6'd32 - merge_sh));
`else
        shifted  = arr_rdata << {rsp_off_q, 3'b000};
`endif
        unique case (rsp_size_q)
            SizeByte: extended = {{24{!rsp_unsigned_q & shifted[31]}}, shifted[31:24]};
            SizeHalf: extended = {{16{!rsp_unsigned_q & shifted[31]}}, shifted[31:16]};
            default:  extended = shifted;
        endcase
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_valid_q & rsp_error_q;
    assign bus.rsp_rdata = (rsp_valid_q && rsp_load_q) ? extended : 32'b0;

endmodule

// File: tb/tb_data_memory_banked.sv
// Self-checking bench for data_memory_banked against a byte-array reference model.
// Follows DATA_MEMORY_MISALIGNED_EN to choose split or reject expectations.
module tb_data_memory_banked;
    localparam int unsigned Depth = 1024;
    localparam int unsigned Bytes = 4 * Depth;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    data_memory_banked_if #(.ADDR_WIDTH(32)) bus ();

    data_memory_banked #(
        .ADDR_WIDTH (32),
        .DEPTH_WORDS(Depth),
        .BASE_ADDR  (0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [0:Bytes-1];

    // Reference: big-endian byte array, range/alignment rules computed arithmetically.
    function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd, output int lat);
        int n;
        longint a;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a = longint'(addr);
        err = (sz == 2'b11) || (a + n - 1 > longint'(Bytes - 1));
`ifndef DATA_MEMORY_MISALIGNED_EN
        if (a % n != 0) err = 1'b1;
`endif
        lat = (!err && (a % 4) + n > 4) ? 2 : 1;
        rd = 32'b0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*(n-1-i) +: 8];
            end else begin
                v = 32'b0;
                for (int i = 0; i < n; i++) v = {v[23:0], ref_mem[int'(a) + i]};
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                rd = v;
            end
        end
    endfunction

    // Drives one request from a negedge and returns {valid, error, rdata, latency} observed
    // and expected; mid_ready is req_ready seen in the cycle before a late response.
    task automatic run_op(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [41:0] obs, output logic [41:0] exp,
                          output logic mid_ready);
        int guard, lat, e_lat;
        logic e_err;
        logic [31:0] e_rd;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 3000) begin
            @(negedge clock);
            guard++;
        end
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        lat = 1;
        mid_ready = 1'b0;
        while (bus.rsp_valid !== 1'b1 && lat < 4) begin
            mid_ready = bus.req_ready;
            @(negedge clock);
            lat++;
        end
        obs = {bus.rsp_valid, bus.rsp_error, bus.rsp_rdata, 8'(lat)};
        model(wr, sz, uns, addr, wd, e_err, e_rd, e_lat);
        exp = {1'b1, e_err, e_rd, 8'(e_lat)};
    endtask

    task automatic release_and_count(input string name);
        int n;
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.req_ready !== 1'b1 && n < 3000);
        checks++;
        if (n != Depth) begin
            errors++;
            $display("FAIL %s ready_delay got %0d want %0d", name, n, Depth);
        end
        for (int i = 0; i < Bytes; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic test_reset();
        logic [41:0] obs, exp;
        logic mr;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'b0; bus.req_wdata = 32'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.rsp_rdata} !== 35'b0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_error, bus.rsp_rdata});
        end
        release_and_count("init");
        run_op(1'b0, 2'b10, 1'b0, 32'h3FC, 32'b0, obs, exp, mr);
        checks++;
        if (obs !== {1'b1, 1'b0, 32'h0, 8'd1}) begin
            errors++;
            $display("FAIL ld_after_init got %h want %h", obs, {1'b1, 1'b0, 32'h0, 8'd1});
        end
    endtask

    task automatic test_store_load();
        logic [41:0] obs, exp;
        logic mr;
        logic [31:0] want [5] = '{32'h0, 32'h22, 32'h3344, 32'hFFFFFF80, 32'h80};
        logic        wr   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0]  sz   [5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        logic        uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ad   [5] = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h20};
        run_op(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0080, obs, exp, mr);
        for (int i = 0; i < 5; i++) begin
            run_op(wr[i], sz[i], uns[i], ad[i], 32'h1122_3344, obs, exp, mr);
            checks++;
            if (obs !== exp || obs[39:8] !== want[i]) begin
                errors++;
                $display("FAIL store_load[%0d] got %h want %h (rdata %h)", i, obs, exp, want[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [41:0] obs, exp;
        logic mr;
        logic [31:0] ad [5] = '{32'h100, 32'h104, 32'h101, 32'h103, 32'h105};
        logic [1:0]  sz [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
        run_op(1'b1, 2'b10, 1'b0, 32'h100, 32'h0102_0304, obs, exp, mr);
        run_op(1'b1, 2'b10, 1'b0, 32'h104, 32'h0506_0708, obs, exp, mr);
        run_op(1'b1, 2'b10, 1'b0, 32'h102, 32'hAABB_CCDD, obs, exp, mr);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL st_word_0x102 got %h want %h", obs, exp);
        end
`ifdef DATA_MEMORY_MISALIGNED_EN
        checks++;
        if (mr !== 1'b0) begin
            errors++;
            $display("FAIL split_ready got %b want 0", mr);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, sz[i], 1'b0, ad[i], 32'b0, obs, exp, mr);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL misaligned_ld[%0d] got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_errors();
        logic [41:0] obs, exp;
        logic mr;
        logic        wr [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]  sz [7] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10, 2'b10};
        logic [31:0] ad [7] = '{32'hFFE, 32'h1000, 32'h0, 32'hFFE, 32'h1000, 32'hFFFF_FFFC,
                                32'hFFC};
        run_op(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hDEAD_BEEF, obs, exp, mr);
        for (int i = 0; i < 7; i++) begin
            run_op(wr[i], sz[i], 1'b0, ad[i], 32'h5555_5555, obs, exp, mr);
            checks++;
            if (obs !== exp || (i == 6 && obs[39:8] !== 32'hDEAD_BEEF)) begin
                errors++;
                $display("FAIL error_case[%0d] got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        logic e_err;
        logic [31:0] e_rd;
        int e_lat;
        for (int k = 0; k < 4; k++) begin
            wd = $urandom;
            bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
            bus.req_unsigned = 1'b0; bus.req_addr = 32'h40 + 32'(4 * k); bus.req_wdata = wd;
            model(1'b1, 2'b10, 1'b0, 32'h40 + 32'(4 * k), wd, e_err, e_rd, e_lat);
            @(posedge clock);
            @(negedge clock);
            checks++;
            if ({bus.rsp_valid, bus.rsp_error, bus.req_ready} !== 3'b101) begin
                errors++;
                $display("FAIL b2b_store[%0d] got %b want 101", k,
                         {bus.rsp_valid, bus.rsp_error, bus.req_ready});
            end
            bus.req_write = 1'b0;
            model(1'b0, 2'b10, 1'b0, 32'h40 + 32'(4 * k), 32'b0, e_err, e_rd, e_lat);
            @(posedge clock);
            @(negedge clock);
            bus.req_valid = 1'b0;
            checks++;
            if ({bus.rsp_valid, bus.rsp_error, bus.rsp_rdata} !== {2'b10, e_rd}) begin
                errors++;
                $display("FAIL b2b_load[%0d] got %h want %h", k,
                         {bus.rsp_valid, bus.rsp_error, bus.rsp_rdata}, {2'b10, e_rd});
            end
            @(negedge clock);
            checks++;
            if ({bus.rsp_valid, bus.rsp_rdata} !== 33'b0) begin
                errors++;
                $display("FAIL idle_rdata[%0d] got %h want 0", k, {bus.rsp_valid, bus.rsp_rdata});
            end
        end
    endtask

    task automatic test_random();
        logic [41:0] obs, exp;
        logic mr;
        logic [1:0] sz;
        logic [31:0] ad;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = ($urandom_range(0, 4) == 0) ? 32'hFF8 + $urandom_range(0, 15)
                                             : 32'h200 + $urandom_range(0, 47);
            run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
                   obs, exp, mr);
            checks++;
            if (obs !== exp || (exp[7:0] == 8'd2 && mr !== 1'b0)) begin
                errors++;
                if (bad < 10) $display("FAIL random[%0d] addr %h got %h want %h", i, ad, obs, exp);
                bad++;
            end
        end
    endtask

    task automatic test_reset_split();
        logic [41:0] obs, exp;
        logic mr;
        logic [31:0] ad [4] = '{32'h10, 32'h100, 32'h104, 32'h200};
        run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, obs, exp, mr);
`ifdef DATA_MEMORY_MISALIGNED_EN
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_addr = 32'h102; bus.req_wdata = 32'hCAFE_F00D;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL split_cycle got %b want 00", {bus.req_ready, bus.rsp_valid});
        end
`endif
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata} !== 34'b0) begin
            errors++;
            $display("FAIL reset_mid got %h want 0", {bus.req_ready, bus.rsp_valid, bus.rsp_rdata});
        end
        release_and_count("reinit");
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, 2'b10, 1'b0, ad[i], 32'b0, obs, exp, mr);
            checks++;
            if (obs !== exp || obs[39:8] !== 32'h0) begin
                errors++;
                $display("FAIL rezero[%0d] got %h want %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_split();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "timeout");
    end
endmodule
